// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg
// Shared definitions for the logic_gate_pipe slice: the width of the
// operation select and the encoding of the eight bitwise operations.
// No ports; imported by logic_gate_pipe and its testbench.
package logic_gate_pkg;

  localparam int OP_W = 3;

  // Every 3-bit code is a real operation, so there is no illegal-op path.
  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_stage.sv
// logic_gate_stage
// One valid/ready register slice of the logic_gate_pipe pipeline.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   up_valid/up_data upstream stage (or the op decode for stage 0)
//   down_ready       downstream slice is loading this cycle (out_ready for the last)
//   ready            this slice loads this cycle (combinational)
//   valid/data       registered contents of the slice
module logic_gate_stage
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // The slice can take new data when it is empty or when its current
  // contents leave this cycle; this term chains back combinationally so a
  // full pipeline still streams one item per cycle.
  assign ready = !valid || down_ready;

  // Data only changes when a valid item arrives, so an empty last stage
  // keeps showing the last emitted result and a stalled stage holds steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
// Registered two-operand bitwise logic unit behind a STAGES-deep
// valid/ready pipeline with full backpressure.
// Parameters: WIDTH (>= 1) operand width, STAGES (1..4) depth = latency.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid, in_ready  producer handshake for op/in1/in2
//   op                  operation select (see logic_gate_pkg)
//   in1, in2            operands
//   out_valid, out_ready consumer handshake for y
//   y                   result (last stage data register)
//   busy                at least one stage holds a result
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  if (WIDTH < 1) begin : g_bad_width
    $error("logic_gate_pipe: WIDTH must be at least 1");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_gate_pipe: STAGES must be in 1..4");
  end

  logic [WIDTH-1:0] result;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0] d [STAGES];
  // Unpacked so each link of the ready chain is its own signal rather than
  // bits of one vector feeding each other.
  logic rdy [STAGES+1];

  // The whole computation happens here in front of stage 0; later stages
  // only carry the result forward.
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_NAND: result = ~(in1 & in2);
      OP_NOR:  result = ~(in1 | in2);
      OP_XOR:  result = in1 ^ in2;
      OP_XNOR: result = ~(in1 ^ in2);
      OP_NOT:  result = ~in1;
      OP_BUF:  result = in1;
      default: result = '0;
    endcase
  end

  assign rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;

    if (i == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = result;
    end else begin : g_next
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    logic_gate_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_v),
      .up_data    (up_d),
      .down_ready (rdy[i+1]),
      .ready      (rdy[i]),
      .valid      (v[i]),
      .data       (d[i])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign y         = d[STAGES-1];
  assign busy      = |v;

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, registered two-operand logic unit: the successor to the single-bit combinational gates. It applies one of eight run-time selectable bitwise operations to two `WIDTH`-bit operands and delivers each result through a `STAGES`-deep valid/ready pipeline with full backpressure. It sits between a producer and a consumer that both speak valid/ready, so it can be dropped into streaming datapaths.

## Interface
- `WIDTH`, 8: operand and result width in bits; legal range is 1 or more.
- `STAGES`, 2: pipeline depth, which is also the latency; legal range is 1..4. Elaboration fails outside this range.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  the producer presents `op`, `in1` and `in2`.
- `in_ready`  out  1  the unit can accept an operation this cycle.
- `op`  in  3  operation select (encoding below).
- `in1`  in  `WIDTH`  operand A.
- `in2`  in  `WIDTH`  operand B.
- `out_valid`  out  1  `y` holds a result.
- `out_ready`  in  1  the consumer takes `y` this cycle.
- `y`  out  `WIDTH`  result.
- `busy`  out  1  at least one pipeline stage holds a result.

## Operation
- Op encoding:
  - 0 AND, 1 OR, 2 NAND, 3 NOR
  - 4 XOR, 5 XNOR
  - 6 NOT `in1` (`in2` ignored), 7 BUF `in1` (`in2` ignored)
- All eight codes are legal; there is no error path.
- An input transfer happens on any edge where `in_valid & in_ready`.
- Output transfer:
  - An output transfer happens on any edge where `out_valid & out_ready`.
  - `y` is the last stage's data register.
- The result is computed combinationally from `op`/`in1`/`in2` and captured into stage 0. Later stages only move data; there is no recomputation.
- Each stage `i` holds `v[i]` and `d[i]`.
  - Stage `i` loads from upstream when `!v[i]` or stage `i` is emptying this cycle.
  - The last stage empties on an output transfer.
  - Stage `i` below the last empties when it is valid and stage `i+1` loads.
- `in_ready = !v[0] | stage0_emptying`. This ready chain is combinational, giving full throughput of one op per cycle.
- `busy = |v`.
- `out_valid = v[STAGES-1]`.
- Results leave in strict acceptance order. Nothing is dropped or duplicated.
- When a stage is not loading, `d[i]` holds its value. `y` is stable while `out_valid & !out_ready`.
- The producer may drop `in_valid` at any time. Holding values while `!in_ready` is the producer's duty; the unit samples only on transfer.

## Timing
- Reset:
  - On any edge with `rst=1`, all `v[i]` and all `d[i]` clear to 0.
  - After that edge: `out_valid=0`, `y=0`, `busy=0`, `in_ready=1`.
  - The cycle after `rst` deasserts, an input can be accepted.
- Reset mid-operation: all in-flight results are discarded. A transfer presented in the same cycle as `rst` is ignored. `rst` has priority over every load.
- Latency: an op accepted at edge k has `out_valid=1` and its result on `y` after edge k+`STAGES`-1. It can transfer out at edge k+`STAGES` at the earliest.
- Full pipeline (all `v`=1) with `out_ready=0`: `in_ready=0`.
- Full pipeline with `out_ready=1`: `in_ready=1`. Accept and emit on the same edge.
- Empty pipeline: `out_valid=0`, `y` keeps the last emitted value.
- Capacity is exactly `STAGES` results.

## Structure
- Package `logic_gate_pkg` holds the `op` encoding constants (`OP_AND` .. `OP_BUF`) and the op width (3).
- Sub-module `logic_gate_stage`: one valid/ready register slice, parametrised by `WIDTH`. The top instantiates it `STAGES` times in a generate loop and places the combinational op decode in front of stage 0.
- Only parameter-range checks live at the top level.

## Test plan
- Reset and idle: assert `rst` for 2 cycles with `in_valid=1` -> `y=0`, `out_valid=0`, `busy=0`, `in_ready=1`, and nothing emerges later.
- Op sweep (`WIDTH=8`, `STAGES=2`, `out_ready=1`): `in1=8'hA5`, `in2=8'h3C`, ops 0..7 on back-to-back cycles -> `y` = 24, BD, DB, 42, 99, 66, 5A, A5 (hex) on consecutive cycles, the first valid 2 cycles after the first accept.
- Backpressure: stream 6 ops with `out_ready=0` for 5 cycles -> exactly 2 accepted, then `in_ready=0` and `y` stable. Release `out_ready` -> all 6 results in order with no gaps.
- Simultaneous accept/emit: full pipeline with `in_valid=1` and `out_ready=1` -> one in and one out per edge, and `busy` stays 1.
- Reset mid-stream: `rst` pulse while 2 results are in flight -> neither result ever appears; the next op after release emerges with normal latency.
- Degenerate config (`WIDTH=1`, `STAGES=1`, op=NOR): (`in1`,`in2`) = 00, 01, 10, 11 -> `y` = 1, 0, 0, 0, each one cycle after accept.
